// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue -- two-stage issue/result wrapper around an external
// combinational ALU.
//
// S1 (issue register) decodes an incoming register- or immediate-form
// integer op into a 4-bit ALU control code. It also holds the two operands,
// the destination tag and an illegal-op flag, and drives the ALU directly
// from these registers. S2 (result register) captures the ALU response
// together with the tag and illegal flag and presents them downstream.
// Latency from acceptance to out_valid is 2 cycles, and throughput is one
// op per cycle.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   flush             synchronous drop of every in-flight op
//   in_valid/in_ready upstream handshake (in_ready is combinational)
//   in_is_imm         0 = register form, 1 = immediate form
//   in_funct3         operation select
//   in_funct7b5       alternate-op bit (register form)
//   in_rs1/in_rs2     operands A / B
//   in_imm            12-bit immediate, sign-extended for immediate form
//   in_tag            destination tag, passed through unchanged
//   alu_control/a/b   registered drive to the ALU
//   alu_result/zero   combinational ALU response
//   out_valid/ready   downstream handshake
//   out_result/zero/tag/illegal  registered result bundle
// ---------------------------------------------------------------------------
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_imm,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [11:0] in_imm,
    input  logic [4:0]  in_tag,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic [4:0]  out_tag,
    output logic        out_illegal
);

    // ALU control encodings
    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_XOR  = 4'b0011;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_SLTU = 4'b1000;
    localparam logic [3:0] CTL_ILL  = 4'b1010;
    localparam logic [3:0] CTL_SLL  = 4'b1100;
    localparam logic [3:0] CTL_SRL  = 4'b1101;
    localparam logic [3:0] CTL_SRA  = 4'b1111;

    // Stage registers
    logic        s1_valid_q, s1_valid_d;
    logic [3:0]  s1_ctrl_q;
    logic [31:0] s1_a_q;
    logic [31:0] s1_b_q;
    logic [4:0]  s1_tag_q;
    logic        s1_ill_q;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q;
    logic        out_zero_q;
    logic [4:0]  out_tag_q;
    logic        out_ill_q;

    // Decode results for the op currently on the input port
    logic [3:0]  dec_ctrl_d;
    logic [31:0] dec_b_d;
    logic        dec_ill_d;
    logic        dec_alt;
    logic [6:0]  imm_hi;

    // Handshake / load enables
    logic s1_load;
    logic s2_load;

    // -----------------------------------------------------------------------
    // Handshake. Flush blocks both stages from loading, so nothing moves and
    // nothing is accepted in the flush cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        s2_load  = s1_valid_q && (!out_valid_q || out_ready) && !flush;
        in_ready = !flush && (!s1_valid_q || s2_load);
        s1_load  = in_valid && in_ready;
    end

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    always_comb begin
        imm_hi     = in_imm[11:5];
        dec_alt    = in_is_imm ? in_imm[10] : in_funct7b5;
        dec_b_d    = in_is_imm ? {{20{in_imm[11]}}, in_imm} : in_rs2;
        dec_ctrl_d = CTL_AND;
        dec_ill_d  = 1'b0;

        unique case (in_funct3)
            3'b000: dec_ctrl_d = (!in_is_imm && in_funct7b5) ? CTL_SUB : CTL_ADD;
            3'b001: dec_ctrl_d = CTL_SLL;
            3'b010: dec_ctrl_d = CTL_SLT;
            3'b011: dec_ctrl_d = CTL_SLTU;
            3'b100: dec_ctrl_d = CTL_XOR;
            3'b101: dec_ctrl_d = dec_alt ? CTL_SRA : CTL_SRL;
            3'b110: dec_ctrl_d = CTL_OR;
            3'b111: dec_ctrl_d = CTL_AND;
            default: dec_ctrl_d = CTL_AND;
        endcase

        if (!in_is_imm) begin
            // Only add/sub and srl/sra have an alternate register-form op.
            if (in_funct7b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101))
                dec_ill_d = 1'b1;
        end else begin
            // Immediate shifts: the upper field must be all-zero, except
            // that srai uses 0100000. slli has no alternate form.
            if (in_funct3 == 3'b001 && imm_hi != 7'b0000000)
                dec_ill_d = 1'b1;
            if (in_funct3 == 3'b101 && imm_hi != 7'b0000000 && imm_hi != 7'b0100000)
                dec_ill_d = 1'b1;
        end

        if (dec_ill_d)
            dec_ctrl_d = CTL_ILL;
    end

    // -----------------------------------------------------------------------
    // Valid next-state
    // -----------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (flush)
            s1_valid_d = 1'b0;
        else if (s1_load)
            s1_valid_d = 1'b1;
        else if (s2_load)
            s1_valid_d = 1'b0;

        out_valid_d = out_valid_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (s2_load)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
    end

    // -----------------------------------------------------------------------
    // Stage S1
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_ctrl_q  <= 4'b0000;
            s1_a_q     <= 32'd0;
            s1_b_q     <= 32'd0;
            s1_tag_q   <= 5'd0;
            s1_ill_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_ctrl_q <= dec_ctrl_d;
                s1_a_q    <= in_rs1;
                s1_b_q    <= dec_b_d;
                s1_tag_q  <= in_tag;
                s1_ill_q  <= dec_ill_d;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage S2. An illegal op is forced to result 0 / zero 1 here, so the
    // outcome does not depend on how the ALU treats the illegal code.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 32'd0;
            out_zero_q   <= 1'b0;
            out_tag_q    <= 5'd0;
            out_ill_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s2_load) begin
                out_result_q <= s1_ill_q ? 32'd0 : alu_result;
                out_zero_q   <= s1_ill_q ? 1'b1  : alu_zero;
                out_tag_q    <= s1_tag_q;
                out_ill_q    <= s1_ill_q;
            end
        end
    end

    assign alu_control = s1_ctrl_q;
    assign alu_a       = s1_a_q;
    assign alu_b       = s1_b_q;

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_imm;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_rs1, in_rs2;
    logic [11:0] in_imm;
    logic [4:0]  in_tag;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_tag;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_imm(in_is_imm), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    // Behavioural ALU attached to the DUT's drive
    always_comb begin
        case (alu_control)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1100: alu_result = alu_a << alu_b[4:0];
            4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1000: alu_result = {31'd0, alu_a < alu_b};
            4'b0011: alu_result = alu_a ^ alu_b;
            4'b1101: alu_result = alu_a >> alu_b[4:0];
            4'b1111: alu_result = $signed(alu_a) >>> alu_b[4:0];
            4'b0001: alu_result = alu_a | alu_b;
            4'b0000: alu_result = alu_a & alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    int tests = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- Reference model (instruction-level) ----------------
    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  tag;
        logic        ill;
        int          acc;
    } item_t;

    item_t q[$];
    int    cyc = 0;

    function automatic item_t ref_exec(bit is_imm, bit [2:0] f3, bit f7, bit [31:0] a,
                                       bit [31:0] rs2, bit [11:0] imm, bit [4:0] tag);
        item_t r;
        bit [31:0] b;
        bit [6:0] hi;
        bit alt;
        bit ill;
        int sh;
        b   = is_imm ? {{20{imm[11]}}, imm} : rs2;
        hi  = imm[11:5];
        alt = is_imm ? imm[10] : f7;
        sh  = int'(b[4:0]);
        ill = (!is_imm && f7 && f3 != 3'd0 && f3 != 3'd5)
           || (is_imm && f3 == 3'd1 && hi != 7'd0)
           || (is_imm && f3 == 3'd5 && hi != 7'd0 && hi != 7'h20);
        case (f3)
            3'd0: r.res = (!is_imm && f7) ? a - b : a + b;
            3'd1: r.res = a << sh;
            3'd2: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r.res = (a < b) ? 32'd1 : 32'd0;
            3'd4: r.res = a ^ b;
            3'd5: r.res = alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: r.res = a | b;
            default: r.res = a & b;
        endcase
        if (ill) r.res = 32'd0;
        r.zero = (r.res == 32'd0);
        r.tag  = tag;
        r.ill  = ill;
        r.acc  = 0;
        return r;
    endfunction

    // One clock cycle: inputs are already set at the current negedge.
    // Checks handshake/output against the queue model, then advances.
    task automatic step(output bit acc, output bit xfer);
        bit exp_vld, exp_rdy;
        item_t it;
        #1;
        exp_vld = (q.size() > 0) && (cyc >= q[0].acc + 2);
        exp_rdy = !flush && (q.size() < 2 || out_ready);
        chk("out_valid", out_valid, exp_vld);
        chk("in_ready", in_ready, exp_rdy);
        if (exp_vld) begin
            chk("out_result", out_result, q[0].res);
            chk("out_zero", out_zero, q[0].zero);
            chk("out_tag", out_tag, q[0].tag);
            chk("out_illegal", out_illegal, q[0].ill);
        end
        xfer = exp_vld && out_ready && !flush;
        acc  = in_valid && exp_rdy;
        if (flush) q.delete();
        else begin
            if (xfer) void'(q.pop_front());
            if (acc) begin
                it = ref_exec(in_is_imm, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, in_tag);
                it.acc = cyc;
                q.push_back(it);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_op(bit is_imm, bit [2:0] f3, bit f7, bit [31:0] a, bit [31:0] b,
                          bit [11:0] imm, bit [4:0] tag);
        in_is_imm = is_imm; in_funct3 = f3; in_funct7b5 = f7;
        in_rs1 = a; in_rs2 = b; in_imm = imm; in_tag = tag;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, " out_valid"}, out_valid, 0);
        chk({pfx, " out_result"}, out_result, 0);
        chk({pfx, " out_zero"}, out_zero, 0);
        chk({pfx, " out_tag"}, out_tag, 0);
        chk({pfx, " out_illegal"}, out_illegal, 0);
        chk({pfx, " alu_control"}, alu_control, 0);
        chk({pfx, " alu_a"}, alu_a, 0);
        chk({pfx, " alu_b"}, alu_b, 0);
    endtask

    typedef struct {
        bit        is_imm;
        bit [2:0]  f3;
        bit        f7;
        bit [31:0] a;
        bit [31:0] b;
        bit [11:0] imm;
        bit [4:0]  tag;
        bit [3:0]  ctrl;
        bit [31:0] res;
        bit        ill;
    } vec_t;

    vec_t vt[15];

    initial begin
        bit acc, xfer;
        int n_acc, n_xfer, first_x, last_x;
        bit [31:0] held;

        vt[0]  = '{0, 3'b000, 1, 32'd5, 32'd7, 12'h000, 5'd3, 4'b0110, 32'hFFFFFFFE, 0};
        vt[1]  = '{1, 3'b101, 0, 32'h80000000, 32'd0, 12'h401, 5'd4, 4'b1111, 32'hC0000000, 0};
        vt[2]  = '{0, 3'b110, 1, 32'h1234, 32'h5678, 12'h000, 5'd5, 4'b1010, 32'd0, 1};
        vt[3]  = '{0, 3'b000, 0, 32'd10, 32'd20, 12'h000, 5'd6, 4'b0010, 32'd30, 0};
        vt[4]  = '{1, 3'b000, 0, 32'd0, 32'd99, 12'hFFF, 5'd7, 4'b0010, 32'hFFFFFFFF, 0};
        vt[5]  = '{0, 3'b010, 0, 32'hFFFFFFFF, 32'd1, 12'h000, 5'd8, 4'b0111, 32'd1, 0};
        vt[6]  = '{0, 3'b011, 0, 32'hFFFFFFFF, 32'd1, 12'h000, 5'd9, 4'b1000, 32'd0, 0};
        vt[7]  = '{0, 3'b100, 0, 32'hF0F0F0F0, 32'h0F0F0F0F, 12'h000, 5'd10, 4'b0011, 32'hFFFFFFFF, 0};
        vt[8]  = '{0, 3'b001, 0, 32'd1, 32'd31, 12'h000, 5'd11, 4'b1100, 32'h80000000, 0};
        vt[9]  = '{0, 3'b101, 0, 32'h80000000, 32'd4, 12'h000, 5'd12, 4'b1101, 32'h08000000, 0};
        vt[10] = '{0, 3'b101, 1, 32'h80000000, 32'd4, 12'h000, 5'd13, 4'b1111, 32'hF8000000, 0};
        vt[11] = '{1, 3'b001, 0, 32'd1, 32'd0, 12'h401, 5'd14, 4'b1010, 32'd0, 1};
        vt[12] = '{1, 3'b101, 0, 32'h80000000, 32'd0, 12'h201, 5'd15, 4'b1010, 32'd0, 1};
        vt[13] = '{0, 3'b111, 0, 32'hFF00FF00, 32'h0FF00FF0, 12'h000, 5'd16, 4'b0000, 32'h0F000F00, 0};
        vt[14] = '{1, 3'b110, 1, 32'd1, 32'd0, 12'h800, 5'd31, 4'b0001, 32'hFFFFF801, 0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(0, 3'd0, 0, 0, 0, 0, 0);

        // Reset state, both before and after a clock edge under reset
        #1 chk_reset_vals("rst");
        @(negedge clk);
        chk_reset_vals("rst_edge");
        reset = 1'b0;
        #1 chk("in_ready after reset", in_ready, 1);
        @(negedge clk);

        // Directed table, one op at a time with out_ready=1
        foreach (vt[i]) begin
            set_op(vt[i].is_imm, vt[i].f3, vt[i].f7, vt[i].a, vt[i].b, vt[i].imm, vt[i].tag);
            in_valid = 1'b1;
            step(acc, xfer);
            chk($sformatf("v%0d accepted", i), acc, 1);
            in_valid = 1'b0;
            chk($sformatf("v%0d alu_control", i), alu_control, vt[i].ctrl);
            step(acc, xfer);
            chk($sformatf("v%0d out_valid", i), out_valid, 1);
            chk($sformatf("v%0d out_result", i), out_result, vt[i].res);
            chk($sformatf("v%0d out_zero", i), out_zero, vt[i].res == 0);
            chk($sformatf("v%0d out_tag", i), out_tag, vt[i].tag);
            chk($sformatf("v%0d out_illegal", i), out_illegal, vt[i].ill);
            step(acc, xfer);
        end

        // Backpressure: 4 back-to-back ops, out_ready low
        out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            set_op(0, 3'd0, 0, 32'd100 * (n_acc + 1), 32'd1, 0, 5'(20 + n_acc));
            in_valid = (n_acc < 4);
            step(acc, xfer);
            if (acc) n_acc++;
            if (c == 2) held = out_result;
        end
        chk("bp accepts", n_acc, 2);
        chk("bp in_ready", in_ready, 0);
        chk("bp out_result held", out_result, held);
        out_ready = 1'b1;
        n_xfer = 0; first_x = -1; last_x = -1;
        for (int c = 0; c < 12; c++) begin
            set_op(0, 3'd0, 0, 32'd100 * (n_acc + 1), 32'd1, 0, 5'(20 + n_acc));
            in_valid = (n_acc < 4);
            step(acc, xfer);
            if (acc) n_acc++;
            if (xfer) begin
                if (first_x < 0) first_x = c;
                last_x = c;
                n_xfer++;
            end
        end
        in_valid = 1'b0;
        chk("bp drained", n_xfer, 4);
        chk("bp consecutive", last_x - first_x, 3);

        // Flush with both stages full
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            set_op(0, 3'd4, 0, 32'hAAAA0000 + c, 32'h1, 0, 5'(c));
            in_valid = 1'b1;
            step(acc, xfer);
        end
        in_valid = 1'b0;
        step(acc, xfer);
        chk("pre-flush out_valid", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        set_op(0, 3'd0, 0, 32'd1, 32'd1, 0, 5'd9);
        step(acc, xfer);
        chk("flush accepted", acc, 0);
        chk("flush no xfer", xfer, 0);
        flush = 1'b0; in_valid = 1'b0;
        chk("post-flush out_valid", out_valid, 0);
        for (int c = 0; c < 3; c++) step(acc, xfer);

        // Asynchronous reset pulse between edges with the pipeline full
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_op(0, 3'd6, 0, 32'h0F0 + c, 32'h100, 0, 5'(c + 1));
            in_valid = (c < 2);
            step(acc, xfer);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #2 reset = 1'b1;
        #1 chk_reset_vals("async");
        #1 reset = 1'b0;
        #0.5 chk("in_ready after pulse", in_ready, 1);
        q.delete();
        @(negedge clk);
        chk("no xfer after pulse", out_valid, 0);

        // Randomised traffic against the queue model
        for (int c = 0; c < 600; c++) begin
            bit [6:0] hi;
            case ($urandom_range(0, 2))
                0: hi = 7'h00;
                1: hi = 7'h20;
                default: hi = 7'($urandom);
            endcase
            set_op(1'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0),
                   $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom,
                   {hi, 5'($urandom)}, 5'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            step(acc, xfer);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step(acc, xfer);
        chk("final drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
